// File: rtl/keypad_scan_interface_pkg.sv
// rtl/keypad_scan_interface_pkg.sv - shared types, widths and key map for the keypad scanner
package keypad_pkg;

    localparam int COL_W = 4;
    localparam int ROW_W = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_PRESS_DEB   = 2'd1,
        S_HELD        = 2'd2,
        S_RELEASE_DEB = 2'd3
    } key_state_t;

    // Hex value of each key, indexed {col, row}; column 0 first, row 0 first
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    // Lowest-numbered active-low row wins when several rows are pulled low
    function automatic logic [IDX_W-1:0] first_low_row(input logic [ROW_W-1:0] rows);
        logic [IDX_W-1:0] idx;
        if (!rows[0])      idx = 2'd0;
        else if (!rows[1]) idx = 2'd1;
        else if (!rows[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_interface_if.sv
// rtl/keypad_scan_interface_if.sv - keypad pins and decoded-key outputs bundle
interface keypad_scan_interface_if;
    import keypad_pkg::*;

    logic [ROW_W-1:0] row_in;
    logic             clear;
    logic [COL_W-1:0] col_out;
    logic             key_valid;
    logic [3:0]       key_code;
    logic [15:0]      data_out;

    // master: keypad/host side; slave: the scanner
    modport master (output row_in, clear, input col_out, key_valid, key_code, data_out);
    modport slave  (input row_in, clear, output col_out, key_valid, key_code, data_out);
endinterface

// File: rtl/keypad_scan_interface_counter.sv
// rtl/keypad_scan_interface_counter.sv - column dwell prescaler and column index counter
module keypad_scan_counter
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic             clock_in,
    input  logic             reset,
    output logic             o_tick,
    output logic [IDX_W-1:0] o_col_idx,
    output logic             o_frame_end
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0]    r_presc;
    logic [IDX_W-1:0] r_col_idx;
    logic             w_tick;

    assign w_tick      = (r_presc == LAST);
    assign o_tick      = w_tick;
    assign o_col_idx   = r_col_idx;
    assign o_frame_end = w_tick && (r_col_idx == 2'd3);

    // Prescaler wraps every dwell; the column advances on the wrap
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_presc   <= '0;
            r_col_idx <= '0;
        end else if (w_tick) begin
            r_presc   <= '0;
            r_col_idx <= r_col_idx + 2'd1;
        end else begin
            r_presc   <= r_presc + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scan_interface.sv
// rtl/keypad_scan_interface.sv - 4x4 keypad scanner with frame debounce and digit shift register
module keypad_scan_interface
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                   clock_in,
    input  logic                   reset,
    keypad_scan_interface_if.slave bus
);

    localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

    logic [ROW_W-1:0] r_row_s1, r_row_s2;
    logic             w_tick, w_frame_end;
    logic [IDX_W-1:0] w_col_idx;
    logic             w_col_hit, w_frame_hit;
    logic [3:0]       w_col_code, w_frame_code;
    logic             r_acc_hit;
    logic [3:0]       r_acc_code;
    key_state_t       r_state, w_state_nx;
    logic [3:0]       r_cnt, w_cnt_nx;
    logic [3:0]       r_cand, w_cand_nx;
    logic             w_accept;
    logic             r_key_valid;
    logic [3:0]       r_key_code;
    logic [15:0]      r_data;

    keypad_scan_counter #(.SCAN_DIV(SCAN_DIV)) u_counter (
        .clock_in    (clock_in),
        .reset       (reset),
        .o_tick      (w_tick),
        .o_col_idx   (w_col_idx),
        .o_frame_end (w_frame_end)
    );

    // Two-flop synchronizer; idle rows read high
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_row_s1 <= '1;
            r_row_s2 <= '1;
        end else begin
            r_row_s1 <= bus.row_in;
            r_row_s2 <= r_row_s1;
        end
    end

    assign w_col_hit    = ~&r_row_s2;
    assign w_col_code   = KEY_MAP[{w_col_idx, first_low_row(r_row_s2)}];
    // The last column's sample is folded in directly so the frame result is complete at frame end
    assign w_frame_hit  = r_acc_hit | w_col_hit;
    assign w_frame_code = r_acc_hit ? r_acc_code : w_col_code;

    // Keep the first hit of the frame in scan order; cleared at frame end
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_acc_hit  <= 1'b0;
            r_acc_code <= '0;
        end else if (w_frame_end) begin
            r_acc_hit  <= 1'b0;
            r_acc_code <= '0;
        end else if (w_tick && !r_acc_hit && w_col_hit) begin
            r_acc_hit  <= 1'b1;
            r_acc_code <= w_col_code;
        end
    end

    // Debounce FSM state register
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_cand  <= w_cand_nx;
        end
    end

    // Debounce FSM next state, evaluated once per frame
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cand_nx  = r_cand;
        if (w_frame_end) begin
            case (r_state)
                S_IDLE: if (w_frame_hit) begin
                    w_cand_nx  = w_frame_code;
                    w_cnt_nx   = 4'd1;
                    w_state_nx = (DEB_N == 4'd1) ? S_HELD : S_PRESS_DEB;
                end
                S_PRESS_DEB: begin
                    if (!w_frame_hit) begin
                        w_state_nx = S_IDLE;
                    end else if (w_frame_code == r_cand) begin
                        w_cnt_nx = r_cnt + 4'd1;
                        if (r_cnt + 4'd1 == DEB_N) w_state_nx = S_HELD;
                    end else begin
                        w_cand_nx = w_frame_code;
                        w_cnt_nx  = 4'd1;
                    end
                end
                S_HELD: if (!w_frame_hit) begin
                    w_cnt_nx   = 4'd1;
                    w_state_nx = (DEB_N == 4'd1) ? S_IDLE : S_RELEASE_DEB;
                end
                S_RELEASE_DEB: begin
                    if (w_frame_hit) begin
                        w_state_nx = S_HELD;
                    end else begin
                        w_cnt_nx = r_cnt + 4'd1;
                        if (r_cnt + 4'd1 == DEB_N) w_state_nx = S_IDLE;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // Accept strobe: the frame that completes a stable press
    always_comb begin
        w_accept = 1'b0;
        if (w_frame_end && w_frame_hit) begin
            if (r_state == S_IDLE && DEB_N == 4'd1)
                w_accept = 1'b1;
            else if (r_state == S_PRESS_DEB && w_frame_code == r_cand && r_cnt + 4'd1 == DEB_N)
                w_accept = 1'b1;
        end
    end

    // Registered outputs; clear beats a simultaneous shift of data_out
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_data      <= '0;
        end else begin
            r_key_valid <= w_accept;
            if (w_accept) r_key_code <= w_frame_code;
            if (bus.clear)     r_data <= '0;
            else if (w_accept) r_data <= {r_data[11:0], w_frame_code};
        end
    end

    assign bus.col_out   = ~(4'b0001 << w_col_idx);
    assign bus.key_valid = r_key_valid;
    assign bus.key_code  = r_key_code;
    assign bus.data_out  = r_data;

endmodule

// File: doc/keypad_scan_interface.md
Name: keypad_scan_interface

Overview:
- Input-side counterpart of the multiplexed seven-segment display driver; scans the Nexys 3 Pmod 4x4 hex keypad (KYPD).
- Drives one keypad column low at a time, samples the rows, debounces, and emits one pulse per key press.
- Shifts each accepted hex digit into a 16-bit value whose format matches the display's data_in, so a keypad entry can drive the display directly.

Parameters:
- SCAN_DIV, 100000, clocks per column dwell (1 ms at 100 MHz); must be >= 2.
- DEBOUNCE_SCANS, 4, consecutive identical full scan frames needed to accept a press or a release; must be 1..15.

Ports:
- clock_in  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- row_in  input  4  keypad rows, active low, externally pulled up; asynchronous to clock_in
- clear  input  1  synchronous clear of data_out
- col_out  output  4  keypad columns, active low, exactly one low at a time
- key_valid  output  1  one-cycle pulse when a debounced press is accepted
- key_code  output  4  hex value of the last accepted key
- data_out  output  16  last four accepted digits; newest digit in [3:0]

Behaviour:
- Interface: one clock (clock_in); reset is asynchronous and active-high, and all state is cleared the moment reset asserts.
- Reset values: col_out=4'b1110, key_valid=0, key_code=0, data_out=0, prescaler=0, column index=0, FSM=IDLE, frame accumulators cleared.
- Sync: row_in passes through a 2-flop synchronizer before any use.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick=1 when the count equals SCAN_DIV-1.
- Column index (2 bits): advances on tick and wraps 3->0. col_out = ~(4'b0001 << col_idx).
- Sampling:
  - The synchronized rows are sampled on tick, before the column advances, so the column has settled for a full dwell.
  - The first low row in scan order is recorded for the frame (column 0 first, then row 0 first). Simultaneous keys resolve to the first in scan order.
- Frame end: tick while col_idx==3. The frame result is {hit, code} and the accumulator clears for the next frame.
- Key map, code by row (0..3) for each column:
  - col0: 1,4,7,0
  - col1: 2,5,8,F
  - col2: 3,6,9,E
  - col3: A,B,C,D
- FSM, evaluated only at frame end:
  - IDLE: hit -> capture candidate=code, cnt=1. If DEBOUNCE_SCANS==1, accept at once and go to HELD; otherwise go to PRESS_DEB.
  - PRESS_DEB: hit with the same code -> cnt++. When cnt reaches DEBOUNCE_SCANS, accept and go to HELD. Hit with a different code -> restart with the new candidate, cnt=1. No hit -> IDLE.
  - HELD: no hit -> cnt=1, go to RELEASE_DEB. Any hit -> stay; no auto-repeat.
  - RELEASE_DEB: no hit -> cnt++; at DEBOUNCE_SCANS go to IDLE. Any hit -> HELD.
- Accept, registered on the cycle after the frame-end tick:
  - key_valid=1 for exactly one cycle.
  - key_code=candidate.
  - data_out={data_out[11:0], candidate}.
- clear: on the next edge data_out=0. If clear coincides with an accept, clear wins for data_out. key_code and key_valid still update.
- Latency: key_valid rises one clock after the frame-end tick of the DEBOUNCE_SCANS-th consecutive matching frame, plus 2 clocks of synchronizer delay on the row inputs.
- Reset asserted mid-frame or mid-debounce: all state is abandoned. The scan restarts at column 0 with no key_valid emitted.

Decomposition:
- Package keypad_pkg:
  - FSM state encoding (IDLE, PRESS_DEB, HELD, RELEASE_DEB).
  - 16-entry KEY_MAP constant indexed {col,row}.
  - Column and row width constants.
- Sub-module keypad_scan_counter: prescaler plus 2-bit column counter, with outputs tick, col_idx and frame_end. It plays the same role as the display's digit-select counter.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, so one frame = 16 clocks):
- Reset, then idle -> col_out cycles 1110,1101,1011,0111, one column per 4 clocks. key_valid stays 0 and data_out=0000.
- Hold row 1 low while col 1 is driven, for 3 frames -> one key_valid pulse 2 frames (+2 sync clocks +1) after press start. key_code=5, data_out=0005. No repeat while held.
- Release for 2 frames, then press 0xA, 0x3, 0xF, 0x7 in turn, each held 3 frames -> data_out=A3F7. A fifth key 0x1 gives 3F71.
- Key present for 1 frame only, or bouncing (alternate hit/no-hit frames) -> no key_valid.
- Keys 2 and E held together -> key_code=2 (scan-order priority). Assert clear in the accept cycle -> data_out=0000, key_code=2, and key_valid still pulses.
- Assert reset during PRESS_DEB (after 1 matching frame) -> outputs return to reset values at once. After release, a full 2-frame press is needed to get key_valid.
